// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 32-bit CPU for a subset of the Nios II I-type instructions.
// One shared instruction/data port and a 32-entry register file with r0 hard-wired to zero.
module cpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        nRst,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData,
    output logic        oMemRead,
    output logic        oMemWrite
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h14;
    localparam logic [5:0] OP_XORI = 6'h1C;
    localparam logic [5:0] OP_LDW  = 6'h17;
    localparam logic [5:0] OP_STW  = 6'h15;
    localparam logic [5:0] OP_BR   = 6'h06;
    localparam logic [5:0] OP_BEQ  = 6'h26;
    localparam logic [5:0] OP_BNE  = 6'h1E;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] result_q, result_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm16;
    logic [5:0]  opcode;
    logic        is_alu;
    logic        is_logic;
    logic [31:0] alu_result;
    logic        wr_en;
    logic [31:0] wr_data;

    assign ra     = ir_q[31:27];
    assign rb     = ir_q[26:22];
    assign imm16  = ir_q[21:6];
    assign opcode = ir_q[5:0];

    // Classify the opcode held in IR; logic ops take a zero-extended immediate.
    always_comb begin
        is_logic = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        is_alu   = is_logic || (opcode == OP_ADDI);
    end

    // ALU operates on the latched rA value and the immediate extended in DECODE.
    always_comb begin
        alu_result = 32'h0;
        case (opcode)
            OP_ADDI: alu_result = a_q + imm_q;
            OP_ANDI: alu_result = a_q & imm_q;
            OP_ORI:  alu_result = a_q | imm_q;
            OP_XORI: alu_result = a_q ^ imm_q;
            default: alu_result = 32'h0;
        endcase
    end

    // Next-state and datapath update for the fetch/decode/execute sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        ea_d     = ea_q;
        mdr_d    = mdr_q;
        result_d = result_q;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = iMemData;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = (ra == 5'd0) ? 32'h0 : regs_q[ra];
                b_d     = (rb == 5'd0) ? 32'h0 : regs_q[rb];
                imm_d   = is_logic ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    result_d = alu_result;
                    state_d  = S_WB;
                end else if ((opcode == OP_LDW) || (opcode == OP_STW)) begin
                    ea_d    = a_q + imm_q;
                    state_d = S_MEM;
                end else if (opcode == OP_BR) begin
                    pc_d    = pc_q + imm_q;
                    state_d = S_FETCH;
                end else if (opcode == OP_BEQ) begin
                    if (a_q == b_q) pc_d = pc_q + imm_q;
                    state_d = S_FETCH;
                end else if (opcode == OP_BNE) begin
                    if (a_q != b_q) pc_d = pc_q + imm_q;
                    state_d = S_FETCH;
                end else begin
                    // Unknown opcodes idle through WB so they take four cycles.
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (opcode == OP_LDW) begin
                    mdr_d   = iMemData;
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                if (opcode == OP_LDW) begin
                    wr_en   = 1'b1;
                    wr_data = mdr_q;
                end else if (is_alu) begin
                    wr_en   = 1'b1;
                    wr_data = result_q;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register file write port; writes aimed at r0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (rb != 5'd0)) regs_d[rb] = wr_data;
    end

    // Moore memory interface driven from the state register and latched operands.
    always_comb begin
        oMemAddr  = pc_q;
        oMemData  = b_q;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        case (state_q)
            S_IDLE: begin
                oMemAddr = 32'h0;
                oMemData = 32'h0;
            end
            S_FETCH: begin
                oMemRead = 1'b1;
            end
            S_MEM: begin
                oMemAddr = ea_q;
                if (opcode == OP_LDW) oMemRead = 1'b1;
                else oMemWrite = 1'b1;
            end
            default: begin
                oMemAddr = pc_q;
            end
        endcase
    end

    // State, datapath registers and register file; reset clears everything at once.
    always_ff @(posedge iClk or posedge nRst) begin
        if (nRst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            imm_q    <= 32'h0;
            ea_q     <= 32'h0;
            mdr_q    <= 32'h0;
            result_q <= 32'h0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            ea_q     <= ea_d;
            mdr_q    <= mdr_d;
            result_q <= result_d;
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed program tests for cpu_core with a small word-addressed memory.
module tb_cpu_core;

    logic        iClk;
    logic        nRst;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [31:0] iMemData;
    logic        oMemRead;
    logic        oMemWrite;

    logic [31:0] mem [0:2047];
    int          n_checks;
    int          n_fail;
    int          store_count;

    cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .oMemAddr  (oMemAddr),
        .oMemData  (oMemData),
        .iMemData  (iMemData),
        .oMemRead  (oMemRead),
        .oMemWrite (oMemWrite)
    );

    assign iMemData = mem[oMemAddr[12:2]];

    // Free-running 10-time-unit clock.
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance n cycles; stores seen in the current cycle land in memory before the edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            checkOutput("strobe_exclusive", {31'b0, oMemRead & oMemWrite}, 32'h0);
            if (oMemWrite) begin
                mem[oMemAddr[12:2]] = oMemData;
                store_count++;
            end
            @(posedge iClk);
            @(negedge iClk);
        end
    endtask

    task automatic enterReset();
        nRst = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        store_count = 0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        store_count = 0;
        nRst        = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;

        // NOP memory: reset outputs and fetch cadence of four cycles.
        enterReset();
        checkOutput("rst_addr", oMemAddr, 32'h0);
        checkOutput("rst_data", oMemData, 32'h0);
        checkOutput("rst_read", {31'b0, oMemRead}, 32'h0);
        checkOutput("rst_write", {31'b0, oMemWrite}, 32'h0);
        nRst = 1'b0;
        applyStimulus(1);
        checkOutput("nop_fetch0_addr", oMemAddr, 32'h0);
        checkOutput("nop_fetch0_read", {31'b0, oMemRead}, 32'h1);
        applyStimulus(1);
        checkOutput("nop_decode_read", {31'b0, oMemRead}, 32'h0);
        checkOutput("nop_decode_addr", oMemAddr, 32'h4);
        applyStimulus(3);
        checkOutput("nop_fetch1_addr", oMemAddr, 32'h4);
        checkOutput("nop_fetch1_read", {31'b0, oMemRead}, 32'h1);
        applyStimulus(4);
        checkOutput("nop_fetch2_addr", oMemAddr, 32'h8);
        checkOutput("nop_no_stores", store_count, 32'd0);

        // ldw / addi / stw / br loop incrementing the word at 0x1000.
        enterReset();
        mem[0]     = 32'h0044_0017;
        mem[1]     = 32'h0840_0044;
        mem[2]     = 32'h0044_0015;
        mem[3]     = 32'h003F_FC06;
        mem[12'h400] = 32'd5;
        nRst = 1'b0;
        applyStimulus(13);
        for (int k = 0; k < 3; k++) begin
            checkOutput("loop_st_write", {31'b0, oMemWrite}, 32'h1);
            checkOutput("loop_st_addr", oMemAddr, 32'h0000_1000);
            checkOutput("loop_st_data", oMemData, 32'd6 + 32'(k));
            applyStimulus(1);
            checkOutput("loop_st_single", {31'b0, oMemWrite}, 32'h0);
            checkOutput("loop_br_fetch", oMemAddr, 32'h0000_000C);
            applyStimulus(3);
            checkOutput("loop_wrap_addr", oMemAddr, 32'h0);
            checkOutput("loop_wrap_read", {31'b0, oMemRead}, 32'h1);
            applyStimulus(12);
        end
        checkOutput("loop_mem_final", mem[12'h400], 32'd8);

        // Sign- versus zero-extended immediates.
        enterReset();
        mem[0] = 32'h007F_FFC4;
        mem[1] = 32'h00BF_FFD4;
        mem[2] = 32'h0044_0015;
        mem[3] = 32'h0084_0115;
        nRst = 1'b0;
        applyStimulus(12);
        checkOutput("sext_write", {31'b0, oMemWrite}, 32'h1);
        checkOutput("sext_addr", oMemAddr, 32'h0000_1000);
        checkOutput("sext_data", oMemData, 32'hFFFF_FFFF);
        applyStimulus(4);
        checkOutput("zext_write", {31'b0, oMemWrite}, 32'h1);
        checkOutput("zext_addr", oMemAddr, 32'h0000_1004);
        checkOutput("zext_data", oMemData, 32'h0000_FFFF);

        // beq taken at 0x0 and bne not taken at 0xC.
        enterReset();
        mem[0] = 32'h0000_0226;
        mem[3] = 32'h0000_021E;
        nRst = 1'b0;
        applyStimulus(3);
        checkOutput("beq_exec_read", {31'b0, oMemRead}, 32'h0);
        applyStimulus(1);
        checkOutput("beq_target", oMemAddr, 32'h0000_000C);
        checkOutput("beq_target_read", {31'b0, oMemRead}, 32'h1);
        applyStimulus(3);
        checkOutput("bne_fallthrough", oMemAddr, 32'h0000_0010);
        checkOutput("bne_fall_read", {31'b0, oMemRead}, 32'h1);

        // Writes to r0 are discarded.
        enterReset();
        mem[0]       = 32'h0000_0144;
        mem[1]       = 32'h0004_0015;
        mem[12'h400] = 32'h0000_DEAD;
        nRst = 1'b0;
        applyStimulus(8);
        checkOutput("r0_write", {31'b0, oMemWrite}, 32'h1);
        checkOutput("r0_addr", oMemAddr, 32'h0000_1000);
        checkOutput("r0_data", oMemData, 32'h0);

        // Reset during the MEM cycle of a store aborts it and clears registers.
        enterReset();
        mem[0]       = 32'h007F_FFC4;
        mem[1]       = 32'h0044_0015;
        mem[12'h400] = 32'h1234_5678;
        nRst = 1'b0;
        applyStimulus(8);
        checkOutput("abort_pre_write", {31'b0, oMemWrite}, 32'h1);
        checkOutput("abort_pre_data", oMemData, 32'hFFFF_FFFF);
        #1 nRst = 1'b1;
        #1;
        checkOutput("abort_write_drop", {31'b0, oMemWrite}, 32'h0);
        checkOutput("abort_addr", oMemAddr, 32'h0);
        checkOutput("abort_mem_kept", mem[12'h400], 32'h1234_5678);
        mem[0] = 32'h0044_0015;
        mem[1] = 32'h0;
        @(negedge iClk);
        nRst = 1'b0;
        applyStimulus(1);
        checkOutput("abort_refetch_addr", oMemAddr, 32'h0);
        checkOutput("abort_refetch_read", {31'b0, oMemRead}, 32'h1);
        applyStimulus(3);
        checkOutput("abort_r1_write", {31'b0, oMemWrite}, 32'h1);
        checkOutput("abort_r1_cleared", oMemData, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
